div_result_collector: RTL
=========================

Name: div_result_collector

Overview:
- Downstream stage of the 4-bit non-restoring divider.
- Takes the raw quotient, raw signed partial remainder, divisor and dividend, and applies the final non-restoring remainder correction.
- Detects divide-by-zero and queues corrected results in a small FIFO.
- Presents results to the consumer over a valid/ready handshake, with overflow/drop accounting.

Parameters:
- QW, 4, quotient/divisor/dividend width; raw remainder is QW+1 bits (two's complement).
- DEPTH, 4, result FIFO depth in entries; power of two, ≥2.
- CW, 8, drop-counter width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  raw result present this cycle
- in_ready  output  1  collector can accept (FIFO not full)
- in_q  input  QW  raw quotient from divider
- in_r  input  QW+1  raw partial remainder (signed)
- in_divisor  input  QW  divisor used for this result
- in_dividend  input  QW  dividend used for this result
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_q  output  QW  corrected quotient
- out_rem  output  QW  corrected remainder
- out_dbz  output  1  head result was divide-by-zero
- level  output  $clog2(DEPTH)+1  current FIFO occupancy
- ovf  output  1  sticky: an input was dropped
- drop_cnt  output  CW  dropped-input count, saturating at all-ones
- clr_ovf  input  1  synchronous pulse: clears ovf and drop_cnt

Behaviour:
- Reset (rst=1, async) clears the following:
  - FIFO pointers; level=0.
  - out_valid=0; out_q=0, out_rem=0, out_dbz=0.
  - ovf=0, drop_cnt=0.
  - Any result in flight is discarded. No partial entry survives reset mid-operation.
- Correction (combinational on input, before the FIFO write):
  - If in_divisor==0: q=all-ones, rem=in_dividend, dbz=1.
  - Else if in_r[QW]==1: rem=(in_r + {1'b0,in_divisor}) truncated to QW+1 bits, then low QW bits taken; q=in_q; dbz=0.
  - Else: rem=in_r[QW-1:0], q=in_q, dbz=0.
- Push: in_valid && in_ready at edge N writes the corrected entry.
  - If FIFO was empty, out_valid=1 with that entry on out_* after edge N (latency 1 clock).
- Pop: out_valid && out_ready at an edge advances the head.
  - out_* always show the head entry, registered, with no combinational path from in_* to out_*.
  - When out_valid=0, out_* hold their last values.
- in_ready = (level != DEPTH). It is registered-state based and does not depend on out_ready.
- Simultaneous push and pop:
  - 0<level<DEPTH: level unchanged, order preserved.
  - level==DEPTH: push refused even if popping.
  - level==0: only a push is possible, since out_valid=0.
- Drop: in_valid && !in_ready sets ovf=1 and increments drop_cnt, saturating at 2^CW-1 with no wrap.
- clr_ovf:
  - Clears ovf and drop_cnt.
  - If a drop occurs in the same cycle, the result is ovf=1, drop_cnt=1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from level.
- FIFO ordering is strict FIFO. Entries are never reordered or duplicated.

Test Plan:
- Positive remainder: in_q=4'h3, in_r=5'h01, divisor 2, dividend 7 → one cycle later out_valid=1, out_q=3, out_rem=1, out_dbz=0, level=1.
- Negative correction: in_q=4'h1, in_r=5'h1E, divisor 3, dividend 4 → out_q=1, out_rem=1 (0x1E+3=0x21→1), out_dbz=0.
- Divide-by-zero: divisor 0, dividend 9, any in_q/in_r → out_q=4'hF, out_rem=9, out_dbz=1.
- Fill/overflow with out_ready=0, five consecutive pushes of q=1..5:
  - in_ready falls after the 4th push; level=4.
  - 5th input dropped: ovf=1, drop_cnt=1.
  - Then out_ready=1 pops q=1,2,3,4 in order; level returns to 0; out_valid falls.
- Simultaneous push/pop at level=2, plus clr_ovf together with a drop at level=4:
  - Push/pop: level stays 2 and output order is intact.
  - clr_ovf with drop: ovf=1, drop_cnt=1.
- Reset mid-stream at level=3 with ovf=1 → all outputs and level return to 0 asynchronously. First push after release appears alone one cycle later.

Source files
------------

// File: rtl/div_result_collector.sv
// Output stage of the 4-bit non-restoring divider: applies the final remainder
// correction, flags divide-by-zero, and buffers results in a small FIFO.
module div_result_collector #(
  parameter int QW    = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [QW-1:0]              in_q,
  input  logic [QW:0]                in_r,
  input  logic [QW-1:0]              in_divisor,
  input  logic [QW-1:0]              in_dividend,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [QW-1:0]              out_q,
  output logic [QW-1:0]              out_rem,
  output logic                       out_dbz,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  output logic [CW-1:0]              drop_cnt,
  input  logic                       clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 2 * QW + 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and ready depends only on state.

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [LW-1:0] level_next;
  logic [EW-1:0] head_r;
  logic [EW-1:0] corr_entry;
  logic [QW:0]   corr_sum;
  logic          push, pop, drop;

  // Final non-restoring step: a negative partial remainder gets the divisor added back.
  always_comb begin
    corr_sum   = in_r + {1'b0, in_divisor};
    corr_entry = {1'b0, in_q, in_r[QW-1:0]};
    if (in_divisor == '0) begin
      corr_entry = {1'b1, {QW{1'b1}}, in_dividend};
    end else if (in_r[QW]) begin
      corr_entry = {1'b0, in_q, corr_sum[QW-1:0]};
    end
  end

  assign in_ready  = (level != LW'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign drop      = in_valid && !in_ready;
  assign rd_next   = pop ? rd_ptr + PW'(1) : rd_ptr;

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= corr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_next;
      level  <= level_next;
    end
  end

  // Head register: when the new head is the entry being written this edge,
  // take it from the correction logic since the memory is not yet updated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= '0;
    end else if (level_next != '0) begin
      if (push && (wr_ptr == rd_next)) begin
        head_r <= corr_entry;
      end else begin
        head_r <= mem[rd_next];
      end
    end
  end

  assign out_dbz = head_r[EW-1];
  assign out_q   = head_r[2*QW-1:QW];
  assign out_rem = head_r[QW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      ovf      <= drop;
      drop_cnt <= drop ? CW'(1) : '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + CW'(1);
      end
    end
  end

endmodule
